// File: rtl/connect4_pkg.sv
// Shared definitions for the Connect-4 board datapath.
//   cell_t  : 2-bit cell / player code (EMPTY, P1, P2); code 2'b11 is never produced.
//   state_t : drop-controller FSM states.
//   COLS, ROWS, CELLS : board geometry.
//   other_player() : returns the opponent of a player code.
package connect4_pkg;

  localparam int COLS  = 7;
  localparam int ROWS  = 6;
  localparam int CELLS = COLS * ROWS;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    P1    = 2'b01,
    P2    = 2'b10
  } cell_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    PLACE = 2'b01,
    CHECK = 2'b10,
    OVER  = 2'b11
  } state_t;

  function automatic cell_t other_player(input cell_t p);
    return (p == P1) ? P2 : P1;
  endfunction

endpackage

// File: rtl/column_stack.sv
// One board column: six cells stacked bottom-up plus a fill-height counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   push       : place 'piece' on top of the stack (ignored when full)
//   piece      : player code to write
//   clear      : synchronous empty-the-column request (wins over push)
//   cells      : 12-bit column image, row r at bits [2r+1:2r], r=0 is the bottom
//   full       : high once six pieces are stacked
module column_stack
  import connect4_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                push,
  input  logic [1:0]          piece,
  input  logic                clear,
  output logic [2*ROWS-1:0]   cells,
  output logic                full
);

  cell_t      cells_q [ROWS];
  cell_t      cells_d [ROWS];
  logic [2:0] height_q, height_d;

  assign full = (height_q == 3'(ROWS));

  always_comb begin
    cells_d  = cells_q;
    height_d = height_q;
    if (clear) begin
      for (int r = 0; r < ROWS; r++) cells_d[r] = EMPTY;
      height_d = '0;
    end else if (push && !full) begin
      // The write lands in the first empty row, which is exactly the current height.
      for (int r = 0; r < ROWS; r++) begin
        if (height_q == 3'(r)) cells_d[r] = cell_t'(piece);
      end
      height_d = height_q + 3'd1;
    end
  end

  // NOTE: this cell array is reset on purpose: it is visible on the board output and
  // must read empty immediately after reset, so it cannot be left as uninitialised RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < ROWS; r++) cells_q[r] <= EMPTY;
      height_q <= '0;
    end else begin
      cells_q  <= cells_d;
      height_q <= height_d;
    end
  end

  always_comb begin
    cells = '0;
    for (int r = 0; r < ROWS; r++) cells[2*r +: 2] = cells_q[r];
  end

endmodule

// File: rtl/board_drop_controller.sv
// Connect-4 move controller: accepts column drops, stacks pieces, consults an
// external victory validator and tracks turn, move count and game result.
//   clk, rst_n  : clock, asynchronous active-low reset
//   clear       : synchronous new-game request (highest priority)
//   drop_valid, drop_col, drop_ready : drop request handshake, columns 0..6
//   win_in      : validator verdict on the registered board, sampled in CHECK
//   board       : 84-bit board, cell (c,r) at bits [2*(6c+r)+1 : 2*(6c+r)]
//   cur_player  : player to move (01/10)
//   drop_done   : one-cycle pulse when a legal move finishes
//   drop_err    : one-cycle pulse when a request is rejected
//   move_count  : pieces placed, 0..42
//   game_over, winner : sticky result (winner 00 on a draw)
module board_drop_controller
  import connect4_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        drop_valid,
  input  logic [2:0]  drop_col,
  output logic        drop_ready,
  input  logic        win_in,
  output logic [83:0] board,
  output logic [1:0]  cur_player,
  output logic        drop_done,
  output logic        drop_err,
  output logic [5:0]  move_count,
  output logic        game_over,
  output logic [1:0]  winner
);

  state_t     state_q, state_d;
  logic [2:0] col_q, col_d;
  cell_t      cur_player_q, cur_player_d;
  logic [5:0] move_count_q, move_count_d;
  logic       game_over_q, game_over_d;
  cell_t      winner_q, winner_d;
  logic       drop_done_q, drop_done_d;
  logic       drop_err_q, drop_err_d;

  // Bit 7 stands for the illegal column index 7, so one lookup rejects both
  // an out-of-range column and a full one.
  logic [7:0] col_full;
  logic [6:0] col_push;

  assign col_full[7] = 1'b1;

  always_comb begin
    col_push = '0;
    for (int c = 0; c < COLS; c++) begin
      col_push[c] = (state_q == PLACE) && !clear && (col_q == 3'(c));
    end
  end

  for (genvar c = 0; c < COLS; c++) begin : g_col
    column_stack u_col (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (col_push[c]),
      .piece (cur_player_q),
      .clear (clear),
      .cells (board[12*c +: 12]),
      .full  (col_full[c])
    );
  end

  // NOTE: every _d signal gets a default before the branches so no path leaves it
  // unassigned; an unassigned path would infer a latch.
  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    cur_player_d = cur_player_q;
    move_count_d = move_count_q;
    game_over_d  = game_over_q;
    winner_d     = winner_q;
    drop_done_d  = 1'b0;
    drop_err_d   = 1'b0;
    if (clear) begin
      state_d      = IDLE;
      col_d        = '0;
      cur_player_d = P1;
      move_count_d = '0;
      game_over_d  = 1'b0;
      winner_d     = EMPTY;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (drop_valid) begin
            if (col_full[drop_col]) begin
              drop_err_d = 1'b1;
            end else begin
              col_d   = drop_col;
              state_d = PLACE;
            end
          end
        end
        PLACE: begin
          if (move_count_q != 6'(CELLS)) move_count_d = move_count_q + 6'd1;
          state_d = CHECK;
        end
        CHECK: begin
          drop_done_d = 1'b1;
          if (win_in) begin
            winner_d    = cur_player_q;
            game_over_d = 1'b1;
            state_d     = OVER;
          end else if (move_count_q == 6'(CELLS)) begin
            winner_d    = EMPTY;
            game_over_d = 1'b1;
            state_d     = OVER;
          end else begin
            cur_player_d = other_player(cur_player_q);
            state_d      = IDLE;
          end
        end
        OVER: ;
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: state is updated only with non-blocking assignments here, so every flop
  // samples the pre-edge values computed above regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      col_q        <= '0;
      cur_player_q <= P1;
      move_count_q <= '0;
      game_over_q  <= 1'b0;
      winner_q     <= EMPTY;
      drop_done_q  <= 1'b0;
      drop_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      cur_player_q <= cur_player_d;
      move_count_q <= move_count_d;
      game_over_q  <= game_over_d;
      winner_q     <= winner_d;
      drop_done_q  <= drop_done_d;
      drop_err_q   <= drop_err_d;
    end
  end

  assign drop_ready = (state_q == IDLE);
  assign cur_player = cur_player_q;
  assign move_count = move_count_q;
  assign game_over  = game_over_q;
  assign winner     = winner_q;
  assign drop_done  = drop_done_q;
  assign drop_err   = drop_err_q;

endmodule

// File: tb/tb_board_drop_controller.sv
// Directed bench for board_drop_controller: inputs driven and outputs sampled on
// the falling edge, expected values written out by hand.
module tb_board_drop_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic        drop_valid;
  logic [2:0]  drop_col;
  logic        drop_ready;
  logic        win_in;
  logic [83:0] board;
  logic [1:0]  cur_player;
  logic        drop_done;
  logic        drop_err;
  logic [5:0]  move_count;
  logic        game_over;
  logic [1:0]  winner;

  int checks   = 0;
  int failures = 0;

  board_drop_controller dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .drop_valid (drop_valid),
    .drop_col   (drop_col),
    .drop_ready (drop_ready),
    .win_in     (win_in),
    .board      (board),
    .cur_player (cur_player),
    .drop_done  (drop_done),
    .drop_err   (drop_err),
    .move_count (move_count),
    .game_over  (game_over),
    .winner     (winner)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [83:0] obs, input logic [83:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Issues one legal drop and returns at the falling edge of the drop_done cycle,
  // where the controller is back in IDLE (or in OVER).
  task automatic do_move(input logic [2:0] col, input logic win);
    drop_col   = col;
    drop_valid = 1'b1;
    win_in     = win;
    tick();
    drop_valid = 1'b0;
    tick();
    tick();
    check("move_drop_done", drop_done, 1'b1);
    win_in = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clear_move_count", move_count, 6'd0);
  endtask

  initial begin
    rst_n      = 1'b0;
    clear      = 1'b0;
    drop_valid = 1'b0;
    drop_col   = 3'd0;
    win_in     = 1'b0;

    // Reset state
    #12;
    check("rst_board", board, 84'h0);
    check("rst_cur_player", cur_player, 2'b01);
    check("rst_move_count", move_count, 6'd0);
    check("rst_game_over", game_over, 1'b0);
    check("rst_winner", winner, 2'b00);
    check("rst_drop_done", drop_done, 1'b0);
    check("rst_drop_err", drop_err, 1'b0);
    check("rst_drop_ready", drop_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // First drop into column 3 with cycle-accurate latency
    drop_col   = 3'd3;
    drop_valid = 1'b1;
    tick();                                   // edge k
    drop_valid = 1'b0;
    check("k1_drop_ready", drop_ready, 1'b0);
    check("k1_drop_done", drop_done, 1'b0);
    check("k1_board", board, 84'h0);
    tick();                                   // edge k+1: piece written
    check("k2_board", board, 84'h1 << 36);
    check("k2_drop_done", drop_done, 1'b0);
    tick();                                   // edge k+2: drop_done in cycle k+3
    check("k3_drop_done", drop_done, 1'b1);
    check("k3_move_count", move_count, 6'd1);
    check("k3_cur_player", cur_player, 2'b10);
    check("k3_drop_ready", drop_ready, 1'b1);
    tick();
    check("k4_drop_done_low", drop_done, 1'b0);
    do_clear();
    check("clear_board", board, 84'h0);
    check("clear_cur_player", cur_player, 2'b01);

    // Fill column 0, then overflow it and request column 7
    for (int i = 0; i < 6; i++) do_move(3'd0, 1'b0);
    check("col0_board", board, 84'h999);
    check("col0_move_count", move_count, 6'd6);
    check("col0_cur_player", cur_player, 2'b01);
    drop_col   = 3'd0;
    drop_valid = 1'b1;
    tick();
    drop_valid = 1'b0;
    check("full_drop_err", drop_err, 1'b1);
    check("full_drop_ready", drop_ready, 1'b1);
    check("full_board", board, 84'h999);
    check("full_move_count", move_count, 6'd6);
    check("full_cur_player", cur_player, 2'b01);
    tick();
    check("full_drop_err_low", drop_err, 1'b0);
    check("full_no_done", drop_done, 1'b0);
    drop_col   = 3'd7;
    drop_valid = 1'b1;
    tick();
    drop_valid = 1'b0;
    check("col7_drop_err", drop_err, 1'b1);
    check("col7_move_count", move_count, 6'd6);
    tick();
    check("col7_drop_err_low", drop_err, 1'b0);
    check("col7_board", board, 84'h999);
    do_clear();

    // P1 builds a vertical four in column 0, P2 answers in column 1
    do_move(3'd0, 1'b0);
    do_move(3'd1, 1'b0);
    do_move(3'd0, 1'b0);
    do_move(3'd1, 1'b0);
    do_move(3'd0, 1'b0);
    do_move(3'd1, 1'b0);
    do_move(3'd0, 1'b1);
    check("win_winner", winner, 2'b01);
    check("win_game_over", game_over, 1'b1);
    check("win_drop_ready", drop_ready, 1'b0);
    check("win_cur_player", cur_player, 2'b01);
    check("win_move_count", move_count, 6'd7);
    check("win_board", board, 84'h2A055);
    drop_col   = 3'd2;
    drop_valid = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    drop_valid = 1'b0;
    check("over_board", board, 84'h2A055);
    check("over_move_count", move_count, 6'd7);
    check("over_drop_done", drop_done, 1'b0);
    check("over_drop_err", drop_err, 1'b0);
    check("over_game_over", game_over, 1'b1);
    check("over_winner", winner, 2'b01);
    do_clear();
    check("after_win_game_over", game_over, 1'b0);
    check("after_win_winner", winner, 2'b00);

    // Full board, no winner: draw
    for (int c = 0; c < 7; c++) begin
      for (int r = 0; r < 6; r++) do_move(3'(c), 1'b0);
    end
    check("draw_winner", winner, 2'b00);
    check("draw_game_over", game_over, 1'b1);
    check("draw_move_count", move_count, 6'd42);
    check("draw_cur_player", cur_player, 2'b10);
    check("draw_drop_ready", drop_ready, 1'b0);
    check("draw_board", board, 84'h999999999999999999999);
    do_clear();

    // clear during CHECK overrides a winning verdict
    drop_col   = 3'd5;
    drop_valid = 1'b1;
    win_in     = 1'b1;
    tick();                                   // PLACE
    drop_valid = 1'b0;
    tick();                                   // CHECK
    clear = 1'b1;
    tick();
    clear  = 1'b0;
    win_in = 1'b0;
    check("clrchk_board", board, 84'h0);
    check("clrchk_game_over", game_over, 1'b0);
    check("clrchk_winner", winner, 2'b00);
    check("clrchk_cur_player", cur_player, 2'b01);
    check("clrchk_drop_done", drop_done, 1'b0);
    check("clrchk_move_count", move_count, 6'd0);
    tick();
    check("clrchk_drop_done_later", drop_done, 1'b0);

    // Asynchronous reset in the middle of PLACE
    do_move(3'd4, 1'b0);
    check("pre_rst_board", board, 84'h1 << 48);
    drop_col   = 3'd2;
    drop_valid = 1'b1;
    tick();                                   // now in PLACE
    drop_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("arst_board", board, 84'h0);
    check("arst_move_count", move_count, 6'd0);
    check("arst_cur_player", cur_player, 2'b01);
    check("arst_drop_ready", drop_ready, 1'b1);
    check("arst_game_over", game_over, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    check("post_rst_board", board, 84'h0);
    check("post_rst_drop_done", drop_done, 1'b0);
    check("post_rst_move_count", move_count, 6'd0);
    do_move(3'd6, 1'b0);
    check("post_rst_move_board", board, 84'h1 << 72);
    check("post_rst_move_count1", move_count, 6'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/board_drop_controller.md
BOARD_DROP_CONTROLLER -- requirements
Module: board_drop_controller

Interface
REQ-001 SHALL have one clock and one reset: the reset is asynchronous and active-low.
REQ-002 SHALL provide port clk, input, 1 bit: rising-edge clock.
REQ-003 SHALL provide port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL provide port clear, input, 1 bit: synchronous new-game request.
REQ-005 SHALL provide port drop_valid, input, 1 bit: drop request.
REQ-006 SHALL provide port drop_col, input, 3 bits: target column 0..6.
REQ-007 SHALL provide port drop_ready, output, 1 bit: request accepted when high with drop_valid.
REQ-008 SHALL provide port win_in, input, 1 bit: result from the downstream victory validator, sampled only in CHECK.
REQ-009 SHALL provide port board, output, 84 bits: cell (c,r) at bits [2*(6c+r)+1 : 2*(6c+r)]; r=0 is the bottom row.
REQ-010 SHALL provide port cur_player, output, 2 bits: player to move, 01=P1, 10=P2.
REQ-011 SHALL provide port drop_done, output, 1 bit: one-cycle pulse when a legal move completes.
REQ-012 SHALL provide port drop_err, output, 1 bit: one-cycle pulse when a request is rejected (column full or drop_col>6).
REQ-013 SHALL provide port move_count, output, 6 bits: pieces placed, 0..42.
REQ-014 SHALL provide port game_over, output, 1 bit: level that stays high until clear or reset.
REQ-015 SHALL provide port winner, output, 2 bits: 00=none/draw, 01=P1, 10=P2.

Function
REQ-016 SHALL encode cells as 00=empty, 01=P1, 10=P2; code 11 SHALL never be written.
REQ-017 SHALL implement FSM states IDLE, PLACE, CHECK, OVER.
REQ-018 SHALL drive drop_ready = (state==IDLE); no requests SHALL be accepted in any other state.
REQ-019 SHALL, on acceptance in IDLE with drop_col<=6 and height[drop_col]<6, latch the column and move to PLACE.
REQ-020 SHALL, on acceptance with drop_col>6 or height[drop_col]==6, stay in IDLE, pulse drop_err the next cycle, and leave board, cur_player and move_count unchanged.
REQ-021 SHALL, in PLACE, write cur_player into cell (col, height[col]), increment height[col] and move_count, then go to CHECK.
REQ-022 SHALL, in CHECK, sample win_in, which must be valid combinationally from the registered board.
REQ-023 SHALL, when win_in=1 in CHECK, set winner=cur_player, set game_over, keep cur_player unchanged, and go to OVER.
REQ-024 SHALL, when win_in=0 and move_count==42 in CHECK, set winner=00, set game_over, and go to OVER (draw).
REQ-025 SHALL, otherwise in CHECK, toggle cur_player (01<->10) and return to IDLE.
REQ-026 SHALL pulse drop_done registered, exactly one cycle, on every CHECK exit; latency is acceptance edge k, PLACE at k+1, CHECK at k+2, drop_done high in cycle k+3.
REQ-027 SHALL hold OVER, ignoring drop_valid, until clear.
REQ-028 SHALL, when clear=1 in any state, restore all reset values at the next edge; clear has priority over drop acceptance and over CHECK results.
REQ-029 SHALL keep height counters at 3 bits, saturating at 6; move_count SHALL never exceed 42.

Reset
REQ-030 SHALL, with rst_n low, asynchronously force: board all 0, all heights 0, state IDLE, cur_player=01, move_count=0, winner=00, game_over=0, drop_done=0, drop_err=0.
REQ-031 SHALL, if reset is asserted in PLACE or CHECK, discard the in-flight move with no partial board write visible after release.

Structure
REQ-032 SHALL take the following from shared package connect4_pkg: cell_t enum (EMPTY, P1, P2), constants COLS=7, ROWS=6, CELLS=42, and the FSM state enum.
REQ-033 SHALL instantiate sub-module column_stack 7 times; each instance holds 6 cells plus a height counter, with inputs push, piece, clear and outputs cells and full.
REQ-034 SHALL keep all outputs registered except drop_ready, which is decoded from the state.

Verification
REQ-035 SHALL cover: after reset, drop col 3 -> cell(3,0)=01, move_count=1, cur_player=10, drop_done pulse at k+3.
REQ-036 SHALL cover: 6 drops into col 0 then a 7th -> drop_err pulse, board and move_count=6 unchanged, cur_player unchanged; also drop_col=7 -> drop_err pulse.
REQ-037 SHALL cover: P1 stacks col 0 rows 0-3 with P2 moves in col 1, win_in from the validator -> winner=01, game_over=1, drop_ready=0, further drops ignored.
REQ-038 SHALL cover: a 42-move sequence with win_in held 0 -> winner=00, game_over=1, move_count=42.
REQ-039 SHALL cover: clear asserted in CHECK with win_in=1 -> next cycle board=0, game_over=0, cur_player=01, no drop_done.
REQ-040 SHALL cover: rst_n pulsed low mid-PLACE -> all outputs at reset values immediately, board=0 after release.
